retospect_bs_loader: RTL and testbench

Host-side bitstream transmitter for the neurochip configuration shift chain. It accepts configuration bytes over a valid/ready handshake and serializes them onto the chain's config_en/bs_in pair. It counts exactly CHAIN_LEN shifted bits, then optionally pulses the network reset (reset_nn). It sits between the pin/host interface and the clockbox head of the chain. It also receives the chain tail (bs_out) for readback.

---
 rtl/retospect_bs_loader.sv | 203 ++++++++++++++++++++
 tb/tb_retospect_bs_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retospect_bs_loader.sv
// retospect_bs_loader
// Host-side bitstream transmitter for the neurochip configuration shift chain.
// Bytes arrive over a valid/ready handshake and are serialized LSB first onto
// the chain's config_en/bs_in pair. Exactly CHAIN_LEN bits are shifted per
// load, after which reset_nn is optionally pulsed and done is raised.
//
// Build option: define RETOSPECT_BSL_READBACK_EN to capture the chain tail
// (bs_out) into readback bytes during the load. Without it rb_byte/rb_valid
// are tied to 0.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             one-cycle load request (honoured only when idle)
//   abort             terminate an active load (SHIFT or NN)
//   byte_in[7:0]      configuration byte, shifted LSB first
//   byte_valid        byte_in valid
//   byte_ready        loader accepts byte_in this cycle
//   cfg_en, cfg_bs    chain config_en / bs_in
//   cfg_ret           chain tail bs_out
//   nn_pulse          chain reset_nn
//   busy              load in progress (state != IDLE)
//   done              one-cycle pulse at load completion
//   rb_byte, rb_valid readback byte and its one-cycle strobe
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 336,
  parameter int CNT_W     = 9,
  parameter int PULSE_NN  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_en,
  output logic       cfg_bs,
  input  logic       cfg_ret,
  output logic       nn_pulse,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_byte,
  output logic       rb_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, NN, DONE} state_t;

  localparam logic [CNT_W:0] LEN_W = (CNT_W+1)'(CHAIN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       pend_q, pend_d;

  logic             shift_now;
  logic             accept;
  logic             last_bit;
  logic [CNT_W:0]   rem_now;
  logic [CNT_W:0]   rem_after;
  logic [3:0]       pend_load;

  // Bits still owed to the chain, before and after this cycle's shift.
  assign rem_now   = LEN_W - {1'b0, bit_cnt_q};
  assign shift_now = (state_q == SHIFT) && (pend_q != 4'd0);
  assign rem_after = rem_now - (CNT_W+1)'(shift_now);
  assign last_bit  = shift_now && (rem_now == (CNT_W+1)'(1));

  // A freshly loaded byte only carries as many bits as the chain still needs;
  // the upper bits of a final partial byte are never shifted.
  assign pend_load = (rem_after >= (CNT_W+1)'(8)) ? 4'd8 : rem_after[3:0];

  // Ready when the shifter is empty or drains its last bit this cycle, and
  // pending bits do not already cover the rest of the chain. abort wins over
  // a simultaneous accept.
  assign byte_ready = (state_q == SHIFT) && !abort && (pend_q <= 4'd1) &&
                      ((CNT_W+1)'(pend_q) < rem_now);
  assign accept     = byte_ready && byte_valid;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          sh_d      = '0;
          pend_d    = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          sh_d    = '0;
          pend_d  = '0;
        end else begin
          if (shift_now) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = sh_q >> 1;
            pend_d    = pend_q - 4'd1;
          end
          if (accept) begin
            sh_d   = byte_in;
            pend_d = pend_load;
          end
          if (last_bit) begin
            state_d = (PULSE_NN != 0) ? NN : DONE;
          end
        end
      end
      NN:      state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      pend_q    <= pend_d;
    end
  end

  assign cfg_en   = shift_now;
  assign cfg_bs   = shift_now & sh_q[0];
  assign nn_pulse = (state_q == NN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

`ifdef RETOSPECT_BSL_READBACK_EN
  logic [7:0] rb_sh_q, rb_sh_d;
  logic [2:0] rb_cnt_q, rb_cnt_d;
  logic [7:0] rb_byte_q, rb_byte_d;
  logic       rb_valid_q, rb_valid_d;
  logic       cap;
  logic [7:0] cap_sh;

  // Tail bit enters at the MSB so the earliest capture ends up at the LSB.
  assign cap    = shift_now && !abort;
  assign cap_sh = {cfg_ret, rb_sh_q[7:1]};

  always_comb begin
    rb_sh_d    = rb_sh_q;
    rb_cnt_d   = rb_cnt_q;
    rb_byte_d  = rb_byte_q;
    rb_valid_d = 1'b0;
    if ((state_q == IDLE) && start) begin
      rb_sh_d  = '0;
      rb_cnt_d = '0;
    end else if (abort && ((state_q == SHIFT) || (state_q == NN))) begin
      rb_sh_d  = '0;
      rb_cnt_d = '0;
    end else if (cap) begin
      rb_cnt_d = rb_cnt_q + 3'd1;
      if (rb_cnt_q == 3'd7) begin
        rb_byte_d  = cap_sh;
        rb_valid_d = 1'b1;
        rb_sh_d    = '0;
      end else if (last_bit) begin
        // Trailing partial byte: right-align the rb_cnt_q+1 captured bits.
        rb_byte_d  = cap_sh >> (3'd7 - rb_cnt_q);
        rb_valid_d = 1'b1;
        rb_sh_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sh_d = cap_sh;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_sh_q    <= '0;
      rb_cnt_q   <= '0;
      rb_byte_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q    <= rb_sh_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_byte_q  <= rb_byte_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_byte  = rb_byte_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_cfg_ret;
  assign unused_cfg_ret = cfg_ret;
  assign rb_byte        = 8'h00;
  assign rb_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_bs_loader.sv
module tb_retospect_bs_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_m, abort_m, valid_m, sel_b;
  logic [7:0] byte_in;
  logic       cfg_ret;

  // DUT A: CHAIN_LEN=16, PULSE_NN=1. DUT B: CHAIN_LEN=12, PULSE_NN=0.
  logic       ready_a, en_a, bs_a, nn_a, busy_a, done_a, rbv_a;
  logic [7:0] rbb_a;
  logic       ready_b, en_b, bs_b, nn_b, busy_b, done_b, rbv_b;
  logic [7:0] rbb_b;
  logic       start_a, start_b, abort_a, abort_b, valid_a, valid_b;

  logic       ready_m, cfg_en_m, cfg_bs_m, nn_m, busy_m, done_m, rbv_m;
  logic [7:0] rbb_m;

  assign start_a = start_m & ~sel_b;
  assign start_b = start_m &  sel_b;
  assign abort_a = abort_m & ~sel_b;
  assign abort_b = abort_m &  sel_b;
  assign valid_a = valid_m & ~sel_b;
  assign valid_b = valid_m &  sel_b;

  assign ready_m  = sel_b ? ready_b : ready_a;
  assign cfg_en_m = sel_b ? en_b    : en_a;
  assign cfg_bs_m = sel_b ? bs_b    : bs_a;
  assign nn_m     = sel_b ? nn_b    : nn_a;
  assign busy_m   = sel_b ? busy_b  : busy_a;
  assign done_m   = sel_b ? done_b  : done_a;
  assign rbv_m    = sel_b ? rbv_b   : rbv_a;
  assign rbb_m    = sel_b ? rbb_b   : rbb_a;

  retospect_bs_loader #(.CHAIN_LEN(16), .CNT_W(5), .PULSE_NN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .byte_in(byte_in), .byte_valid(valid_a), .byte_ready(ready_a),
    .cfg_en(en_a), .cfg_bs(bs_a), .cfg_ret(cfg_ret), .nn_pulse(nn_a),
    .busy(busy_a), .done(done_a), .rb_byte(rbb_a), .rb_valid(rbv_a));

  retospect_bs_loader #(.CHAIN_LEN(12), .CNT_W(4), .PULSE_NN(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .byte_in(byte_in), .byte_valid(valid_b), .byte_ready(ready_b),
    .cfg_en(en_b), .cfg_bs(bs_b), .cfg_ret(cfg_ret), .nn_pulse(nn_b),
    .busy(busy_b), .done(done_b), .rb_byte(rbb_b), .rb_valid(rbv_b));

  always #5 clk = ~clk;

  // 16-bit model of the configuration chain feeding the tail back.
  logic [15:0] chain_m = '0;
  logic [15:0] preload_val = '0;
  logic        load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req)      chain_m <= preload_val;
    else if (cfg_en_m) chain_m <= {chain_m[14:0], cfg_bs_m};
  end
  assign cfg_ret = chain_m[15];

  int tests = 0;
  int fails = 0;
  int cur_len = 16;
  int pushed = 0;
  logic bitq[$];
  logic [7:0] rbq[$];
  logic rb_chk = 1'b0;

  int en_cnt = 0, gaps = 0, low_run = 0, nn_cnt = 0, done_cnt = 0, rbv_cnt = 0;
  logic seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every shifted bit and every readback byte is popped here.
  always @(negedge clk) begin
    if (cfg_en_m) begin
      en_cnt++;
      gaps += low_run;
      low_run = 0;
      seen = 1'b1;
      if (bitq.size() == 0) chk("cfg_bs_unexpected", 32'd1, 32'd0);
      else chk("cfg_bs", cfg_bs_m, bitq.pop_front());
    end else if (busy_m && seen && !nn_m && !done_m) begin
      low_run++;
    end
    if (!busy_m) begin
      seen = 1'b0;
      low_run = 0;
    end
    if (busy_m) chk("en_nn_overlap", cfg_en_m & nn_m, 32'd0);
    if (!busy_m) chk("en_outside_shift", cfg_en_m, 32'd0);
    if (nn_m) nn_cnt++;
    if (done_m) done_cnt++;
    if (rbv_m) begin
      rbv_cnt++;
      if (rb_chk) begin
        if (rbq.size() == 0) chk("rb_unexpected", 32'd1, 32'd0);
        else chk("rb_byte", rbb_m, rbq.pop_front());
      end
    end
  end

  task automatic do_start();
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    pushed = 0;
    bitq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    byte_in = b;
    valid_m = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ready_m) begin
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
          if (pushed < cur_len) begin
            bitq.push_back(b[k]);
            pushed++;
          end
        end
      end
      @(posedge clk); #1;
    end
    valid_m = 1'b0;
    chk("byte_accepted", ok, 32'd1);
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ready_m) ok = 1'b1;
    end
    chk("ready_seen", ok, 32'd1);
  endtask

  // Leaves the bench at the negedge of the first cycle after the last shift.
  task automatic wait_end();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!cfg_en_m) ok = 1'b1;
    end
    chk("load_end_seen", ok, 32'd1);
  endtask

  task automatic end_pulse_nn();
    chk("nn_after_last", nn_m, 32'd1);
    chk("done_not_yet", done_m, 32'd0);
    @(negedge clk);
    chk("done_pulse", done_m, 32'd1);
    chk("nn_single", nn_m, 32'd0);
    @(negedge clk);
    chk("busy_after_done", busy_m, 32'd0);
    chk("done_single", done_m, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, g0, nn0, d0, r0;
    logic [7:0] lo, hi;
    reset = 1'b1; start_m = 0; abort_m = 0; valid_m = 0; sel_b = 0; byte_in = 0;
    #12;
    chk("rst_busy", busy_m, 0);
    chk("rst_cfg_en", cfg_en_m, 0);
    chk("rst_ready", ready_m, 0);
    chk("rst_nn", nn_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_rb_valid", rbv_m, 0);
    chk("rst_rb_byte", rbb_m, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: reset mid-SHIFT
    do_start();
    send_byte(8'hA5);
    repeat (2) begin @(posedge clk); #1; end
    chk("t1_shifting", cfg_en_m, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_cfg_en", cfg_en_m, 0);
    chk("t1_rst_ready", ready_m, 0);
    chk("t1_rst_busy", busy_m, 0);
    chk("t1_rst_nn", nn_m, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", busy_m, 0);
    bitq.delete();
    @(posedge clk); #1;

    // Test 2: back-to-back bytes
    en0 = en_cnt; g0 = gaps;
    do_start();
    send_byte(8'hA5);
    send_byte(8'h3C);
    wait_end();
    end_pulse_nn();
    chk("t2_en_cycles", en_cnt - en0, 16);
    chk("t2_gaps", gaps - g0, 0);
    chk("t2_queue_empty", bitq.size(), 0);
    @(posedge clk); #1;

    // Test 3: three-cycle byte stall
    en0 = en_cnt; g0 = gaps;
    do_start();
    send_byte(8'hA5);
    wait_ready();
    repeat (3) begin @(posedge clk); #1; end
    send_byte(8'h3C);
    wait_end();
    end_pulse_nn();
    chk("t3_en_cycles", en_cnt - en0, 16);
    chk("t3_gaps", gaps - g0, 3);
    chk("t3_queue_empty", bitq.size(), 0);
    @(posedge clk); #1;

    // Test 4: CHAIN_LEN=12, PULSE_NN=0, partial final byte
    sel_b = 1'b1; cur_len = 12;
    en0 = en_cnt; nn0 = nn_cnt;
    do_start();
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    chk("t4_ready_low", ready_m, 0);
    wait_end();
    chk("t4_done_next", done_m, 1);
    chk("t4_no_nn", nn_m, 0);
    @(negedge clk);
    chk("t4_busy_after", busy_m, 0);
    chk("t4_en_cycles", en_cnt - en0, 12);
    chk("t4_nn_count", nn_cnt - nn0, 0);
    chk("t4_queue_empty", bitq.size(), 0);
    @(posedge clk); #1;
    sel_b = 1'b0; cur_len = 16;
    @(posedge clk); #1;

`ifdef RETOSPECT_BSL_READBACK_EN
    // Test 5: readback of previous chain contents
    lo = 8'h34; hi = 8'h12;
    for (int i = 0; i < 8; i++) begin
      preload_val[15-i] = lo[i];
      preload_val[7-i]  = hi[i];
    end
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    r0 = rbv_cnt;
    rbq.push_back(8'h34);
    rbq.push_back(8'h12);
    rb_chk = 1'b1;
    do_start();
    send_byte(8'hFF);
    send_byte(8'hFF);
    wait_end();
    end_pulse_nn();
    chk("t5_rb_count", rbv_cnt - r0, 2);
    chk("t5_rbq_empty", rbq.size(), 0);
    chk("t5_chain_ff", chain_m, 16'hFFFF);
    rb_chk = 1'b0;
    @(posedge clk); #1;
`else
    chk("t5_rb_byte_tied", rbb_m, 0);
    chk("t5_rb_valid_tied", rbv_m, 0);
`endif

    // Test 6: abort during bit 5 of the first byte
    nn0 = nn_cnt; d0 = done_cnt; r0 = rbv_cnt;
    do_start();
    send_byte(8'hA5);
    repeat (5) begin @(posedge clk); #1; end
    chk("t6_in_shift", cfg_en_m, 1);
    abort_m = 1'b1;
    @(posedge clk); #1;
    abort_m = 1'b0;
    @(negedge clk);
    chk("t6_idle", busy_m, 0);
    chk("t6_cfg_en", cfg_en_m, 0);
    repeat (4) @(negedge clk);
    chk("t6_no_nn", nn_cnt - nn0, 0);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_no_rb", rbv_cnt - r0, 0);
    bitq.delete();
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    chk("t6_restart_busy", busy_m, 1);
    @(posedge clk); #1;
    send_byte(8'h5A);
    send_byte(8'hC3);
    wait_end();
    end_pulse_nn();
    chk("t6_queue_empty", bitq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
